// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with registered status strobes and combinational flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is a registered read.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_MARGIN  = 1,
    parameter int unsigned AE_MARGIN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    wr_ack,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    full,
    output logic                    almostfull,
    output logic                    empty,
    output logic                    almostempty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_acc_c;
    logic                  wr_acc_c;

    // A write at full is only admitted when a read frees the head slot in the same cycle.
    assign rd_acc_c = rd_en && !empty;
    assign wr_acc_c = wr_en && (!full || rd_en);

    assign empty       = (count == CW'(0));
    assign full        = (count == CW'(DEPTH));
    assign almostfull  = (count >= CW'(DEPTH - AF_MARGIN)) && !full;
    assign almostempty = (count <= CW'(AE_MARGIN)) && !empty;

    // Storage is deliberately left unreset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc_c;
            overflow  <= wr_en && !wr_acc_c;
            underflow <= rd_en && !rd_acc_c;
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    // Head word is captured on the accepting edge, giving one cycle of read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_acc_c) begin
            data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule
